// File: rtl/edge_relaxer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : edge_relaxer_if
// Description : Signal bundle between the relaxation stage, its controller,
//               the EdgeCache and the distance/predecessor table.
//               master : controller/environment side (drives start, node data,
//                        EdgeCache responses and distance-table read data).
//               slave  : edge_relaxer side (drives queries, table index,
//                        update strobes, busy and done).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

interface edge_relaxer_if #(
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
);
    // Sweep request
    logic                   start;
    logic [INDEX_WIDTH-1:0] current_node;
    logic [VALUE_WIDTH-1:0] current_distance;
    logic [INDEX_WIDTH-1:0] number_of_nodes;
    // EdgeCache query
    logic                   query_enable;
    logic [INDEX_WIDTH-1:0] from_node;
    logic [INDEX_WIDTH-1:0] to_node;
    logic                   edge_ready;
    logic [VALUE_WIDTH-1:0] edge_value;
    // Distance table read
    logic [INDEX_WIDTH-1:0] dist_index;
    logic [VALUE_WIDTH-1:0] dist_read_value;
    logic                   node_visited;
    // Distance table update
    logic                   update_valid;
    logic [INDEX_WIDTH-1:0] update_index;
    logic [VALUE_WIDTH-1:0] update_distance;
    logic [INDEX_WIDTH-1:0] update_previous;
    // Status
    logic                   busy;
    logic                   done;

    modport master (
        output start, current_node, current_distance, number_of_nodes,
        output edge_ready, edge_value, dist_read_value, node_visited,
        input  query_enable, from_node, to_node, dist_index,
        input  update_valid, update_index, update_distance, update_previous,
        input  busy, done
    );

    modport slave (
        input  start, current_node, current_distance, number_of_nodes,
        input  edge_ready, edge_value, dist_read_value, node_visited,
        output query_enable, from_node, to_node, dist_index,
        output update_valid, update_index, update_distance, update_previous,
        output busy, done
    );
endinterface

`default_nettype wire

// File: rtl/edge_relaxer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : edge_relaxer
// Description : Dijkstra relaxation stage. For a settled node u with distance
//               dist[u], walks v = 0..N-1, fetches edge(u,v) from EdgeCache,
//               and emits one update strobe for every v whose distance
//               improves through u.
// Ports       : clock        - system clock, posedge
//               reset        - synchronous, active-high
//               bus (slave)  - start/node inputs, EdgeCache query handshake,
//                              distance-table read, update strobe, busy/done
// Options     : SKIP_VISITED_EN - when defined, visited nodes are skipped
//               without issuing an EdgeCache query.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module edge_relaxer #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input  wire logic     clock,
    input  wire logic     reset,
    edge_relaxer_if.slave bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CHECK   = 3'd1;
    localparam logic [2:0] c_QUERY   = 3'd2;
    localparam logic [2:0] c_COMPARE = 3'd3;
    localparam logic [2:0] c_ADVANCE = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    // One bit wider than an index so MAX_NODES == 2**INDEX_WIDTH still fits.
    localparam logic [INDEX_WIDTH:0]   c_MAX_N   = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_ONE = 1;
    localparam logic [VALUE_WIDTH-1:0] c_INF     = '1;

    logic [2:0]             state_q,    state_d;
    logic [INDEX_WIDTH-1:0] u_q,        u_d;
    logic [VALUE_WIDTH-1:0] dist_u_q,   dist_u_d;
    logic [INDEX_WIDTH-1:0] n_q,        n_d;
    logic [INDEX_WIDTH-1:0] v_q,        v_d;
    logic [VALUE_WIDTH-1:0] w_q,        w_d;
    logic                   upd_vld_q,  upd_vld_d;
    logic [INDEX_WIDTH-1:0] upd_idx_q,  upd_idx_d;
    logic [VALUE_WIDTH-1:0] upd_dist_q, upd_dist_d;
    logic [INDEX_WIDTH-1:0] upd_prev_q, upd_prev_d;

    logic [INDEX_WIDTH-1:0] w_n_clip;
    logic [VALUE_WIDTH:0]   w_sum;
    logic                   w_improve;
    logic                   w_skip;

    assign w_n_clip = ({1'b0, bus.number_of_nodes} > c_MAX_N) ?
                      c_MAX_N[INDEX_WIDTH-1:0] : bus.number_of_nodes;

    // Carry bit of the widened sum flags overflow, which counts as infinity.
    assign w_sum     = {1'b0, dist_u_q} + {1'b0, w_q};
    assign w_improve = (w_q != '0) && (dist_u_q != c_INF) && !w_sum[VALUE_WIDTH]
                       && (w_sum[VALUE_WIDTH-1:0] < bus.dist_read_value);

`ifdef SKIP_VISITED_EN
    assign w_skip = (v_q == u_q) || bus.node_visited;
`else
    // Settled nodes cannot improve with non-negative weights, so ignoring the
    // visited flag only costs cycles, never correctness.
    logic w_unused_visited;
    assign w_unused_visited = bus.node_visited;
    assign w_skip           = (v_q == u_q);
`endif

    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        dist_u_d   = dist_u_q;
        n_d        = n_q;
        v_d        = v_q;
        w_d        = w_q;
        upd_vld_d  = 1'b0;
        upd_idx_d  = upd_idx_q;
        upd_dist_d = upd_dist_q;
        upd_prev_d = upd_prev_q;
        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    u_d      = bus.current_node;
                    dist_u_d = bus.current_distance;
                    n_d      = w_n_clip;
                    v_d      = '0;
                    state_d  = (w_n_clip == '0) ? c_DONE : c_CHECK;
                end
            end
            c_CHECK: begin
                state_d = w_skip ? c_ADVANCE : c_QUERY;
            end
            c_QUERY: begin
                if (bus.edge_ready) begin
                    w_d     = bus.edge_value;
                    state_d = c_COMPARE;
                end
            end
            c_COMPARE: begin
                if (w_improve) begin
                    upd_vld_d  = 1'b1;
                    upd_idx_d  = v_q;
                    upd_dist_d = w_sum[VALUE_WIDTH-1:0];
                    upd_prev_d = u_q;
                end
                state_d = c_ADVANCE;
            end
            c_ADVANCE: begin
                if (v_q == n_q - c_IDX_ONE) begin
                    state_d = c_DONE;
                end else begin
                    v_d     = v_q + c_IDX_ONE;
                    state_d = c_CHECK;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= c_IDLE;
            u_q        <= '0;
            dist_u_q   <= '0;
            n_q        <= '0;
            v_q        <= '0;
            w_q        <= '0;
            upd_vld_q  <= 1'b0;
            upd_idx_q  <= '0;
            upd_dist_q <= '0;
            upd_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            dist_u_q   <= dist_u_d;
            n_q        <= n_d;
            v_q        <= v_d;
            w_q        <= w_d;
            upd_vld_q  <= upd_vld_d;
            upd_idx_q  <= upd_idx_d;
            upd_dist_q <= upd_dist_d;
            upd_prev_q <= upd_prev_d;
        end
    end

    assign bus.query_enable    = (state_q == c_QUERY);
    assign bus.from_node       = u_q;
    assign bus.to_node         = v_q;
    assign bus.dist_index      = v_q;
    assign bus.update_valid    = upd_vld_q;
    assign bus.update_index    = upd_idx_q;
    assign bus.update_distance = upd_dist_q;
    assign bus.update_previous = upd_prev_q;
    assign bus.busy            = (state_q != c_IDLE);
    assign bus.done            = (state_q == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_edge_relaxer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_edge_relaxer
// Description : Self-checking bench for edge_relaxer. Models EdgeCache with a
//               programmable latency and the distance table as arrays, and
//               predicts each sweep's updates, query count and busy length
//               from the relaxation rules.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module tb_edge_relaxer;

    localparam int MAXN = `DEFAULT_MAX_NODES;
    localparam int IW   = `DEFAULT_INDEX_WIDTH;
    localparam int VW   = `DEFAULT_VALUE_WIDTH;
    localparam int NIDX = 1 << IW;
    localparam int INF  = (1 << VW) - 1;

    typedef struct {
        int idx;
        int d;
        int prev;
    } upd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    edge_relaxer_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus();

    edge_relaxer #(.MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Environment: EdgeCache, distance table, visited flags
    logic [VW-1:0] edge_w   [NIDX][NIDX];
    logic [VW-1:0] dist_tab [NIDX];
    logic          visited  [NIDX];
    int            lat = 1;
    int            qcnt = 0;

    always @(posedge clock) begin
        if (!bus.query_enable || bus.edge_ready) qcnt <= 0;
        else                                     qcnt <= qcnt + 1;
    end

    assign bus.edge_ready      = bus.query_enable && (qcnt == lat - 1);
    assign bus.edge_value      = edge_w[bus.from_node][bus.to_node];
    assign bus.dist_read_value = dist_tab[bus.dist_index];
    assign bus.node_visited    = visited[bus.dist_index];

    // Monitor
    upd_t          got_upd[$];
    upd_t          exp_upd[$];
    int            done_cnt, busy_cyc, query_cnt, hs_err, qrun;
    logic          prev_qe;
    logic [IW-1:0] prev_from, prev_to;

    always @(negedge clock) begin
        if (bus.update_valid)
            got_upd.push_back('{int'(bus.update_index), int'(bus.update_distance),
                                int'(bus.update_previous)});
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cyc++;
        if (bus.query_enable) begin
            if (!prev_qe) begin
                query_cnt++;
                qrun = 1;
            end else begin
                qrun++;
                if (bus.from_node !== prev_from || bus.to_node !== prev_to) hs_err++;
            end
        end else if (prev_qe === 1'b1 && qrun != lat) begin
            hs_err++;
        end
        prev_qe   = bus.query_enable;
        prev_from = bus.from_node;
        prev_to   = bus.to_node;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {bus.query_enable, bus.from_node, bus.to_node, bus.dist_index,
                bus.update_valid, bus.update_index, bus.update_distance,
                bus.update_previous, bus.busy, bus.done};
    endfunction

    // Reference: relaxation rules applied node by node
    task automatic model(input int u, input int du, input int n,
                         output int exp_q, output int exp_cyc);
        int nc;
        bit skip;
        int w, s;
        exp_upd.delete();
        nc      = (n > MAXN) ? MAXN : n;
        exp_q   = 0;
        exp_cyc = 1;
        for (int v = 0; v < nc; v++) begin
            skip = (v == u);
`ifdef SKIP_VISITED_EN
            if (visited[v]) skip = 1'b1;
`endif
            if (skip) begin
                exp_cyc += 2;
                continue;
            end
            exp_q++;
            exp_cyc += lat + 3;
            w = int'(edge_w[u][v]);
            s = du + w;
            if (w != 0 && du != INF && s <= INF && s < int'(dist_tab[v]))
                exp_upd.push_back('{v, s, u});
        end
    endtask

    task automatic kick(input int u, input int du, input int n);
        @(negedge clock);
        got_upd.delete();
        done_cnt  = 0;
        busy_cyc  = 0;
        query_cnt = 0;
        hs_err    = 0;
        bus.current_node     = IW'(u);
        bus.current_distance = VW'(du);
        bus.number_of_nodes  = IW'(n);
        bus.start            = 1'b1;
        @(negedge clock);
        bus.start            = 1'b0;
        // Port changes during the sweep must have no effect
        bus.current_node     = IW'($urandom);
        bus.current_distance = VW'($urandom);
        bus.number_of_nodes  = IW'($urandom);
    endtask

    task automatic run_sweep(input string tag, input int u, input int du, input int n);
        int  exp_q, exp_cyc;
        bit  seen;
        model(u, du, n, exp_q, exp_cyc);
        kick(u, du, n);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        @(negedge clock);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " n_updates"}, 32'(got_upd.size()), 32'(exp_upd.size()));
        for (int k = 0; k < exp_upd.size() && k < got_upd.size(); k++) begin
            check({tag, " upd_idx"},  32'(got_upd[k].idx),  32'(exp_upd[k].idx));
            check({tag, " upd_dist"}, 32'(got_upd[k].d),    32'(exp_upd[k].d));
            check({tag, " upd_prev"}, 32'(got_upd[k].prev), 32'(exp_upd[k].prev));
        end
        check({tag, " queries"},   32'(query_cnt), 32'(exp_q));
        check({tag, " busy_cyc"},  32'(busy_cyc),  32'(exp_cyc));
        check({tag, " handshake"}, 32'(hs_err),    32'd0);
    endtask

    task automatic setup_default();
        for (int r = 0; r < NIDX; r++) begin
            dist_tab[r] = VW'(INF);
            visited[r]  = 1'b0;
            for (int c = 0; c < NIDX; c++)
                edge_w[r][c] = (r < 4 && c < 4) ? VW'(r * c) : '0;
        end
    endtask

    initial begin
        bit found;
        bus.start            = 1'b0;
        bus.current_node     = '0;
        bus.current_distance = '0;
        bus.number_of_nodes  = '0;
        setup_default();

        // Reset state
        repeat (3) @(negedge clock);
        check("reset outputs", out_vec(), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle outputs", out_vec(), 32'd0);

        // Single sweep: updates (2,2,1) then (3,3,1)
        lat = 1;
        run_sweep("single", 1, 0, 4);
        check("single explicit n", 32'(got_upd.size()), 32'd2);

        // Non-improvement: only v=3 improves
        dist_tab[2] = 8'd1;
        dist_tab[3] = 8'd10;
        run_sweep("noimprove", 1, 0, 4);

        // Tie at v=2 gives no update
        dist_tab[2] = 8'd2;
        dist_tab[3] = VW'(INF);
        run_sweep("tie", 1, 0, 4);

        // Overflow: 250 + 6 = 256 exceeds the value range
        setup_default();
        edge_w[3][2] = 8'd6;
        run_sweep("overflow", 3, 250, 4);

        // Infinite source distance never relaxes
        run_sweep("inf_src", 1, INF, 4);

        // Slow EdgeCache: 3 queried nodes x 8 + 2 + 1 = 27 busy cycles
        lat = 5;
        run_sweep("latency5", 1, 0, 4);
        check("latency5 explicit busy", 32'(busy_cyc), 32'd27);

        // Empty graph: done right after start, no queries
        lat = 1;
        run_sweep("n_zero", 1, 0, 0);

        // Reset in the middle of the query for v=2
        lat = 5;
        kick(1, 0, 4);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.query_enable && bus.to_node == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("midreset reached_v2", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midreset outputs", out_vec(), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset no_update", 32'(got_upd.size()), 32'd0);
        check("midreset no_done", 32'(done_cnt), 32'd0);
        check("midreset idle", 32'(bus.busy), 32'd0);
        run_sweep("after_reset", 2, 0, 4);

`ifdef SKIP_VISITED_EN
        // Visited v=3 is skipped entirely
        lat = 1;
        setup_default();
        visited[3] = 1'b1;
        run_sweep("skip_visited", 1, 0, 4);
        visited[3] = 1'b0;
`endif

        // Randomised sweeps, including N above capacity
        for (int t = 0; t < 25; t++) begin
            int u, du, n;
            lat = int'($urandom_range(1, 4));
            for (int r = 0; r < NIDX; r++) begin
                dist_tab[r] = ($urandom_range(0, 3) == 0) ? VW'(INF) : VW'($urandom);
                visited[r]  = ($urandom_range(0, 3) == 0);
                for (int c = 0; c < NIDX; c++)
                    edge_w[r][c] = ($urandom_range(0, 2) == 0) ? '0 : VW'($urandom_range(1, 120));
            end
            u = int'($urandom_range(0, NIDX - 1));
            case ($urandom_range(0, 3))
                0:       du = 0;
                1:       du = int'($urandom_range(INF - 10, INF));
                default: du = int'($urandom_range(0, INF));
            endcase
            n = int'($urandom_range(0, NIDX - 1));
            run_sweep("random", u, du, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
